// File: rtl/vgg_acc_pkg.sv
// -----------------------------------------------------------------------------
// vgg_acc_pkg
// Shared definitions for the VGG accelerator weight-load scheduler.
//   - state_t   : controller states
//   - NUM_WORDS : 32-bit beats per layer load (4 int8 weights per beat)
//   - NUM_BATCH : batches per layer (matches the store's 3-bit batch wrap)
//   - SW_LAG    : cycles from a switch pulse to the store's 1x1 index update
// -----------------------------------------------------------------------------
package vgg_acc_pkg;

   localparam int NUM_WORDS = 200;
   localparam int NUM_BATCH = 8;
   localparam int SW_LAG    = 6;

   localparam int W_BYTE    = 8;
   localparam int LANES     = 4;
   localparam int STREAM_W  = W_BYTE * LANES;

   localparam int WCNT_W    = $clog2(NUM_WORDS + 1);
   localparam int BATCH_W   = $clog2(NUM_BATCH);
   localparam int GUARD_W   = $clog2(SW_LAG + 1);

   typedef logic signed [W_BYTE-1:0] weight_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      GUARD = 3'd3,
      DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/weight_load_sched_if.sv
// -----------------------------------------------------------------------------
// weight_load_sched_if
// Bundles the weight stream and the weight-store connection of the scheduler.
//   s_data/s_valid/s_ready : incoming 32-bit weight stream
//   w1..w4/w_valid         : weight writes towards the store
//   weight_ing             : store status, high while it still accepts weights
//   switch_conv33/batch_idx: batch advance pulse and current batch
// Modports: slave = scheduler side, master = stream source / store side.
// -----------------------------------------------------------------------------
interface weight_load_sched_if
   import vgg_acc_pkg::*;
   ();

   logic [STREAM_W-1:0] s_data;
   logic                s_valid;
   logic                s_ready;
   weight_t             w1;
   weight_t             w2;
   weight_t             w3;
   weight_t             w4;
   logic                w_valid;
   logic                weight_ing;
   logic                switch_conv33;
   logic [BATCH_W-1:0]  batch_idx;

   modport slave (
      input  s_data, s_valid, weight_ing,
      output s_ready, w1, w2, w3, w4, w_valid, switch_conv33, batch_idx
   );

   modport master (
      output s_data, s_valid, weight_ing,
      input  s_ready, w1, w2, w3, w4, w_valid, switch_conv33, batch_idx
   );

endinterface

// File: rtl/wls_stream_unpack.sv
// -----------------------------------------------------------------------------
// wls_stream_unpack
// One register stage from the 32-bit weight stream to four byte lanes plus a
// write strobe, with the per-layer beat counter and s_ready generation.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : restart the beat counter (layer start)
//   load_next  : controller will be in LOAD next cycle
//   s_data/s_valid/s_ready : stream handshake
//   w_lane     : byte lanes, lane 0 = s_data[7:0]
//   w_valid    : strobe, exactly one cycle after each accepted beat
//   word_cnt   : beats accepted in this layer, saturates at NUM_WORDS
// -----------------------------------------------------------------------------
module wls_stream_unpack
   import vgg_acc_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   input  logic                          load_next,
   input  logic [STREAM_W-1:0]           s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic [LANES-1:0][W_BYTE-1:0]  w_lane,
   output logic                          w_valid,
   output logic [WCNT_W-1:0]             word_cnt
);

   logic                         s_ready_reg;
   logic                         s_ready_next;
   logic                         w_valid_reg;
   logic [WCNT_W-1:0]            word_cnt_reg;
   logic [WCNT_W-1:0]            word_cnt_next;
   logic [LANES-1:0][W_BYTE-1:0] lane_reg;
   logic                         beat;

   // s_ready is only ever high below NUM_WORDS, so the increment never
   // passes the saturation point.
   assign beat = s_valid & s_ready_reg;

   always_comb begin
      word_cnt_next = word_cnt_reg;
      if (clear) begin
         word_cnt_next = '0;
      end else if (beat) begin
         word_cnt_next = word_cnt_reg + 1'b1;
      end
      // Registered ready looks ahead so it drops in the cycle right after
      // the final beat.
      s_ready_next = load_next && (word_cnt_next < WCNT_W'(NUM_WORDS));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_ready_reg  <= 1'b0;
         w_valid_reg  <= 1'b0;
         word_cnt_reg <= '0;
      end else begin
         s_ready_reg  <= s_ready_next;
         w_valid_reg  <= beat;
         word_cnt_reg <= word_cnt_next;
      end
   end

   // Lanes hold their last value between beats.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      always_ff @(posedge clk) begin
         if (rst) begin
            lane_reg[gi] <= '0;
         end else if (beat) begin
            lane_reg[gi] <= s_data[gi*W_BYTE +: W_BYTE];
         end
      end
   end

   assign s_ready  = s_ready_reg;
   assign w_valid  = w_valid_reg;
   assign w_lane   = lane_reg;
   assign word_cnt = word_cnt_reg;

endmodule

// File: rtl/weight_load_sched.sv
// -----------------------------------------------------------------------------
// weight_load_sched
// Sequences the on-chip weight store for one VGG conv layer pass: loads the
// weight stream into the store, then gates the conv engine batch by batch,
// pausing after each batch switch until the store's lagging 1x1 index settles.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a layer (taken in IDLE only)
//   tile_done  : engine finished the current batch
//   run_en     : engine may compute with the current weights
//   busy       : controller not idle
//   layer_done : one-cycle completion pulse
//   err        : sticky protocol error (dropped tile_done, early store stop)
//   bus        : stream + store connection (weight_load_sched_if.slave)
// All outputs are registered.
// -----------------------------------------------------------------------------
module weight_load_sched
   import vgg_acc_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      tile_done,
   output logic                      run_en,
   output logic                      busy,
   output logic                      layer_done,
   output logic                      err,
   weight_load_sched_if.slave        bus
);

   state_t                       state_reg;
   state_t                       state_next;
   logic [BATCH_W-1:0]           batch_reg;
   logic [BATCH_W-1:0]           batch_next;
   logic [GUARD_W-1:0]           guard_reg;
   logic [GUARD_W-1:0]           guard_next;
   logic                         switch_reg;
   logic                         switch_next;
   logic                         run_en_reg;
   logic                         run_en_next;
   logic                         busy_reg;
   logic                         busy_next;
   logic                         layer_done_reg;
   logic                         layer_done_next;
   logic                         err_reg;
   logic                         err_next;

   logic                         clear;
   logic                         load_next;
   logic                         w_valid;
   logic [WCNT_W-1:0]            word_cnt;
   logic [LANES-1:0][W_BYTE-1:0] w_lane;
   logic                         s_ready;

   wls_stream_unpack u_unpack (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .load_next (load_next),
      .s_data    (bus.s_data),
      .s_valid   (bus.s_valid),
      .s_ready   (s_ready),
      .w_lane    (w_lane),
      .w_valid   (w_valid),
      .word_cnt  (word_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         batch_reg      <= '0;
         guard_reg      <= '0;
         switch_reg     <= 1'b0;
         run_en_reg     <= 1'b0;
         busy_reg       <= 1'b0;
         layer_done_reg <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         batch_reg      <= batch_next;
         guard_reg      <= guard_next;
         switch_reg     <= switch_next;
         run_en_reg     <= run_en_next;
         busy_reg       <= busy_next;
         layer_done_reg <= layer_done_next;
         err_reg        <= err_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      batch_next  = batch_reg;
      guard_next  = guard_reg;
      switch_next = 1'b0;
      err_next    = err_reg;
      clear       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               clear = 1'b1;
               // Store already holds the weights when it is not accepting.
               state_next = bus.weight_ing ? LOAD : RUN;
            end
         end
         LOAD: begin
            if (word_cnt < WCNT_W'(NUM_WORDS)) begin
               if (!bus.weight_ing) begin
                  err_next   = 1'b1;
                  state_next = RUN;
               end
            end else if (!w_valid && !bus.weight_ing) begin
               // Final strobe is out; store has confirmed it is full.
               state_next = RUN;
            end
         end
         RUN: begin
            if (tile_done) begin
               switch_next = 1'b1;
               batch_next  = batch_reg + 1'b1;
               guard_next  = GUARD_W'(SW_LAG);
               state_next  = GUARD;
            end
         end
         GUARD: begin
            if (guard_reg == '0) begin
               // batch_reg wrapped to 0 means the last batch was just switched.
               state_next = (batch_reg == '0) ? DONE : RUN;
            end else begin
               guard_next = guard_reg - 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // tile_done is only meaningful in RUN; elsewhere it is dropped.
      if (tile_done && (state_reg != RUN)) begin
         err_next = 1'b1;
      end

      run_en_next     = (state_next == RUN);
      busy_next       = (state_next != IDLE);
      layer_done_next = (state_next == DONE);
      load_next       = (state_next == LOAD);
   end

   assign bus.s_ready       = s_ready;
   assign bus.w1            = $signed(w_lane[0]);
   assign bus.w2            = $signed(w_lane[1]);
   assign bus.w3            = $signed(w_lane[2]);
   assign bus.w4            = $signed(w_lane[3]);
   assign bus.w_valid       = w_valid;
   assign bus.switch_conv33 = switch_reg;
   assign bus.batch_idx     = batch_reg;

   assign run_en     = run_en_reg;
   assign busy       = busy_reg;
   assign layer_done = layer_done_reg;
   assign err        = err_reg;

endmodule

// File: tb/tb_weight_load_sched.sv
// -----------------------------------------------------------------------------
// tb_weight_load_sched
// Directed bench for weight_load_sched: load, throttled load, batch sequencing,
// resident-weights start, dropped tile_done errors and mid-operation resets.
// -----------------------------------------------------------------------------
module tb_weight_load_sched;

   logic clk;
   logic rst;
   logic start;
   logic tile_done;
   logic run_en;
   logic busy;
   logic layer_done;
   logic err;

   weight_load_sched_if bus ();

   weight_load_sched dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .tile_done  (tile_done),
      .run_en     (run_en),
      .busy       (busy),
      .layer_done (layer_done),
      .err        (err),
      .bus        (bus.slave)
   );

   int n_tests;
   int n_fail;
   int cyc;
   int wv_count;
   bit beat_prev;
   logic [31:0] data_prev;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Strobe monitor: every w_valid must follow exactly one beat, with its data.
   initial begin
      beat_prev = 1'b0;
      data_prev = '0;
      cyc       = 0;
      wv_count  = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            beat_prev = 1'b0;
         end else begin
            if (bus.w_valid || beat_prev)
               check_eq("wv_after_beat", {31'b0, bus.w_valid}, {31'b0, beat_prev});
            if (bus.w_valid && beat_prev) begin
               check_eq("w1_byte0", {24'b0, bus.w1}, {24'b0, data_prev[7:0]});
               check_eq("w4_byte3", {24'b0, bus.w4}, {24'b0, data_prev[31:24]});
               wv_count++;
            end
            beat_prev = bus.s_valid & bus.s_ready;
            data_prev = bus.s_data;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_s_ready"}, {31'b0, bus.s_ready}, 32'd0);
      check_eq({tag, "_w_valid"}, {31'b0, bus.w_valid}, 32'd0);
      check_eq({tag, "_w1234"}, {bus.w1, bus.w2, bus.w3, bus.w4}, 32'd0);
      check_eq({tag, "_switch"}, {31'b0, bus.switch_conv33}, 32'd0);
      check_eq({tag, "_batch"}, {29'b0, bus.batch_idx}, 32'd0);
      check_eq({tag, "_run_en"}, {31'b0, run_en}, 32'd0);
      check_eq({tag, "_busy"}, {31'b0, busy}, 32'd0);
      check_eq({tag, "_layer_done"}, {31'b0, layer_done}, 32'd0);
      check_eq({tag, "_err"}, {31'b0, err}, 32'd0);
   endtask

   // Sends n beats 0x04030201+k; throttle idles s_valid every other cycle.
   task automatic send_beats(input int n, input bit throttle, input bit exp_ready_after);
      int k;
      int lim;
      bit took;
      k   = 0;
      lim = 0;
      while (k < n && lim < 2000) begin
         if (throttle && (lim % 2 == 1)) begin
            bus.s_valid = 1'b0;
         end else begin
            bus.s_valid = 1'b1;
            bus.s_data  = 32'h04030201 + 32'(k);
         end
         took = bus.s_valid && bus.s_ready;
         tick();
         lim++;
         if (took) k++;
      end
      bus.s_valid = 1'b0;
      check_eq("beats_sent", 32'(k), 32'(n));
      check_eq("s_ready_after_beats", {31'b0, bus.s_ready}, {31'b0, exp_ready_after});
   endtask

   // Store model: drop weight_ing once 200 strobes have been seen.
   task automatic store_drop(input int base);
      int lim;
      lim = 0;
      while ((wv_count - base) < 200 && lim < 20) begin
         tick();
         lim++;
      end
      check_eq("wv_count", 32'(wv_count - base), 32'd200);
      bus.weight_ing = 1'b0;
   endtask

   task automatic wait_run(input int lim_max);
      int lim;
      lim = 0;
      while (!run_en && lim < lim_max) begin
         tick();
         lim++;
      end
      check_eq("run_en_wait", {31'b0, run_en}, 32'd1);
   endtask

   // Runs all 8 batches; inject drops a tile_done into the guard of batch 3.
   task automatic run_batches(input bit inject);
      int low;
      int sw_last;
      sw_last = 0;
      for (int b = 1; b <= 8; b++) begin
         wait_run(20);
         tile_done = 1'b1;
         tick();
         tile_done = 1'b0;
         check_eq("switch_pulse", {31'b0, bus.switch_conv33}, 32'd1);
         check_eq("run_en_off", {31'b0, run_en}, 32'd0);
         check_eq("batch_idx", {29'b0, bus.batch_idx}, 32'(b % 8));
         if (b > 1) check_eq("sw_spacing", 32'(cyc - sw_last), 32'd8);
         sw_last = cyc;
         low = 1;
         while (low < 20) begin
            if (inject && b == 3 && low == 3) tile_done = 1'b1;
            tick();
            tile_done = 1'b0;
            if (inject && b == 3 && low == 3) begin
               check_eq("no_sw_in_guard", {31'b0, bus.switch_conv33}, 32'd0);
               check_eq("err_guard", {31'b0, err}, 32'd1);
            end
            if (run_en || layer_done) break;
            low++;
         end
         check_eq("run_en_low_cycles", 32'(low), 32'd7);
      end
      check_eq("layer_done", {31'b0, layer_done}, 32'd1);
      check_eq("busy_in_done", {31'b0, busy}, 32'd1);
      check_eq("batch_wrapped", {29'b0, bus.batch_idx}, 32'd0);
      tick();
      check_eq("layer_done_once", {31'b0, layer_done}, 32'd0);
      check_eq("busy_after", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int base;
      n_tests        = 0;
      n_fail         = 0;
      rst            = 1'b1;
      start          = 1'b0;
      tile_done      = 1'b0;
      bus.s_valid    = 1'b0;
      bus.s_data     = '0;
      bus.weight_ing = 1'b0;
      repeat (3) tick();
      check_idle("reset");
      rst = 1'b0;
      tick();

      // Full load, store drops weight_ing after 200 strobes.
      bus.weight_ing = 1'b1;
      pulse_start();
      check_eq("t1_busy", {31'b0, busy}, 32'd1);
      check_eq("t1_s_ready", {31'b0, bus.s_ready}, 32'd1);
      check_eq("t1_run_en", {31'b0, run_en}, 32'd0);
      base = wv_count;
      send_beats(200, 1'b0, 1'b0);
      store_drop(base);
      wait_run(10);
      check_eq("t1_batch", {29'b0, bus.batch_idx}, 32'd0);
      check_eq("t1_err", {31'b0, err}, 32'd0);
      $display("[TB] load of 200 beats complete");

      // Eight batches.
      run_batches(1'b0);
      check_eq("t3_err", {31'b0, err}, 32'd0);
      $display("[TB] batch sequence complete");

      // Resident weights: straight to RUN.
      pulse_start();
      check_eq("t4_s_ready", {31'b0, bus.s_ready}, 32'd0);
      check_eq("t4_w_valid", {31'b0, bus.w_valid}, 32'd0);
      check_eq("t4_run_en", {31'b0, run_en}, 32'd1);
      check_eq("t4_batch", {29'b0, bus.batch_idx}, 32'd0);
      run_batches(1'b0);
      $display("[TB] resident-weight layer complete");

      // Throttled load with stray tile_done in LOAD and GUARD.
      bus.weight_ing = 1'b1;
      pulse_start();
      tile_done = 1'b1;
      tick();
      tile_done = 1'b0;
      check_eq("t5_err_load", {31'b0, err}, 32'd1);
      check_eq("t5_no_sw_load", {31'b0, bus.switch_conv33}, 32'd0);
      check_eq("t5_s_ready", {31'b0, bus.s_ready}, 32'd1);
      base = wv_count;
      send_beats(200, 1'b1, 1'b0);
      store_drop(base);
      wait_run(10);
      run_batches(1'b1);
      check_eq("t5_err_sticky", {31'b0, err}, 32'd1);
      $display("[TB] throttled layer with stray tile_done complete");

      // Reset inside GUARD.
      pulse_start();
      check_eq("t6_run_en", {31'b0, run_en}, 32'd1);
      tile_done = 1'b1;
      tick();
      tile_done = 1'b0;
      check_eq("t6_switch", {31'b0, bus.switch_conv33}, 32'd1);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rst_guard");
      $display("[TB] reset in GUARD done");

      // Reset after 100 beats, then a clean full reload.
      bus.weight_ing = 1'b1;
      pulse_start();
      send_beats(100, 1'b0, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rst_load");
      tick();
      pulse_start();
      check_eq("t6_restart_ready", {31'b0, bus.s_ready}, 32'd1);
      base = wv_count;
      send_beats(200, 1'b0, 1'b0);
      store_drop(base);
      wait_run(10);
      check_eq("t6_batch", {29'b0, bus.batch_idx}, 32'd0);
      check_eq("t6_err", {31'b0, err}, 32'd0);
      $display("[TB] reset in LOAD and restart done");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
